// File: rtl/dcache_controller.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Burst line fill on load miss, byte-strobed write-through on store.
module dcache_controller #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int WO = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - WO - 2;
  localparam logic [WO-1:0] LAST = WO'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE, FILL, WRITE, DONE
  } state_t;

  state_t state, state_n;
  logic [WO-1:0] cnt, cnt_n;

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [WO-1:0] wo;
  assign tag = cpu_addr[31 -: TW];
  assign idx = cpu_addr[WO+2 +: IW];
  assign wo  = cpu_addr[2 +: WO];

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS][LINE_WORDS];

  logic        hit;
  logic [31:0] word;
  assign hit  = valid[idx] && (tags[idx] == tag);
  assign word = data[idx][wo];

  logic        req_n, we_n;
  logic [31:0] addr_n, wdata_n;
  logic [3:0]  wstrb_n;
  logic        fill_we, line_set, inval, merge;
  logic        ack;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  assign ack = mem_req && mem_ack;

  always_comb begin
    st_strb = 4'b1111;
    st_data = cpu_wdata;
    case (cpu_mask)
      3'b000: begin
        st_strb = 4'b0001 << cpu_addr[1:0];
        st_data = {4{cpu_wdata[7:0]}};
      end
      3'b001: begin
        st_strb = cpu_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_n     = mem_req;
    we_n      = mem_we;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    wstrb_n   = mem_wstrb;
    cpu_stall = 1'b0;
    fill_we   = 1'b0;
    line_set  = 1'b0;
    inval     = 1'b0;
    merge     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr_en) begin
          cpu_stall = 1'b1;
          state_n   = WRITE;
          req_n     = 1'b1;
          we_n      = 1'b1;
          addr_n    = {cpu_addr[31:2], 2'b00};
          wdata_n   = st_data;
          wstrb_n   = st_strb;
        end else if (cpu_rd_en && !hit) begin
          cpu_stall = 1'b1;
          state_n   = FILL;
          cnt_n     = '0;
          inval     = 1'b1;
          req_n     = 1'b1;
          we_n      = 1'b0;
          addr_n    = {tag, idx, {WO{1'b0}}, 2'b00};
          wdata_n   = '0;
          wstrb_n   = '0;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        if (ack) begin
          fill_we = 1'b1;
          cnt_n   = cnt + WO'(1);
          addr_n  = {tag, idx, cnt_n, 2'b00};
          if (cnt == LAST) begin
            line_set = 1'b1;
            cnt_n    = '0;
            req_n    = 1'b0;
            addr_n   = '0;
            state_n  = IDLE;
          end
        end
      end
      WRITE: begin
        cpu_stall = 1'b1;
        if (ack) begin
          merge   = hit;
          req_n   = 1'b0;
          we_n    = 1'b0;
          addr_n  = '0;
          wdata_n = '0;
          wstrb_n = '0;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_wstrb <= wstrb_n;
    end
  end

  // The line being refilled stays invalid until its last word lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (inval)    valid[idx] <= 1'b0;
      if (line_set) valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data[idx][cnt] <= mem_rdata;
    if (line_set) tags[idx] <= tag;
    if (merge) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) data[idx][wo][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_fmt;
  assign ld_b = word[{cpu_addr[1:0], 3'b000} +: 8];
  assign ld_h = word[{cpu_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (cpu_mask)
      3'b000:  ld_fmt = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_fmt = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_fmt = {24'b0, ld_b};
      3'b101:  ld_fmt = {16'b0, ld_h};
      default: ld_fmt = word;
    endcase
  end

  assign cpu_rdata = (state == IDLE && cpu_rd_en && !cpu_wr_en && hit)
                   ? ld_fmt : 32'h0;

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache sitting between the core's load/store port and the shared memory bus. It accepts the core's `rd_en`/`wr_en`/`addr`/`wdata`/`mask` request and returns formatted load data, asserting `cpu_stall` while it services misses and stores. On the memory side it issues single-word req/ack transactions: burst line fills on load miss, and byte-strobed write-through on every store. It is the first per-core building block toward the multicore cache hierarchy.

## Interface
- `SETS`, 16: number of lines; power of two.
- `LINE_WORDS`, 4: 32-bit words per line; power of two.
- Address split: byte offset [1:0], word offset [log2(LINE_WORDS)+1:2], index next log2(SETS) bits, tag the remaining upper bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_rd_en`  in  1  load request.
- `cpu_wr_en`  in  1  store request; wins if both enables are high.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, low-aligned.
- `cpu_mask`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `cpu_rdata`  out  32  formatted load data, combinational.
- `cpu_stall`  out  1  core holds PC and request while high, combinational.
- `mem_req`  out  1  memory transaction valid.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  word-aligned address.
- `mem_wdata`  out  32  write data, lane-replicated.
- `mem_wstrb`  out  4  byte strobes.
- `mem_ack`  in  1  transaction completes on the edge where `mem_req` and `mem_ack` are both high.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.

## Operation
- Storage: per line, a valid bit, a tag, and LINE_WORDS data words. Hit means valid and tag equal.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - load hit: `cpu_stall`=0 and `cpu_rdata` is valid in the same cycle.
  - load miss: `cpu_stall`=1, go to FILL, word counter = 0.
  - store (hit or miss): `cpu_stall`=1, go to WRITE.
  - no request: `cpu_stall`=0.
- FILL:
  - `mem_req`=1, `mem_we`=0, `mem_addr`={tag, index, cnt, 00}.
  - On ack: write `mem_rdata` into line word `cnt`, then cnt+1.
  - On ack with cnt = LINE_WORDS-1: set valid, write tag, go to IDLE. The held load then hits.
  - Valid stays 0 for the line during the fill.
- WRITE:
  - `mem_req`=1, `mem_we`=1, `mem_addr`=addr with [1:0] cleared.
  - `mem_wstrb`: SB = 0001<<addr[1:0]; SH = 0011<<(2·addr[1]); SW = 1111.
  - `mem_wdata`: SB = byte replicated ×4; SH = half ×2; SW = word.
  - On ack: if hit, merge strobed bytes into the cached word (miss: no allocate, cache unchanged); go to DONE.
- DONE:
  - `cpu_stall`=0 for exactly one cycle, so the core retires the store.
  - Any request seen this cycle is ignored. Next state is IDLE.
- Load format: select byte `addr[1:0]` / half `addr[1]` / word. B and H sign-extend; BU and HU zero-extend.
  - Misaligned H/W: ignore the low address bits (align down).
  - Undefined mask: treat as W.
- `cpu_rdata` = 0 when not a load hit.

## Timing
- Reset values: state IDLE, all valid bits 0, counter 0, `mem_req`/`mem_we`/`mem_wstrb`/`mem_addr`/`mem_wdata` = 0. `cpu_stall` = 0 with no request.
- `mem_*` outputs are registered. They stay stable while `mem_req`=1 and no ack has occurred.
- `mem_ack` is permitted in the first cycle of `mem_req`.
- `mem_req` may stay high across consecutive fill words; the address advances after each ack.
- Zero-wait memory (ack every cycle):
  - load miss = 5 stall cycles: 1 IDLE + 4 FILL; data is returned in cycle 6.
  - store = 2 stall cycles (IDLE, WRITE), then DONE.
- Each memory wait cycle adds one stall cycle.
- Reset asserted mid-FILL or mid-WRITE: immediate abort. `mem_req` drops asynchronously, the partial line stays invalid, and the memory side must reset with the cache.
- `mem_ack` while `mem_req`=0 is ignored.

## Test plan
- Cold LW 0x0000_0040 (memory words 0x40..0x4C = 0x11111111…0x44444444, ack every cycle):
  - mem reads issued to 0x40, 0x44, 0x48, 0x4C in order; stall high for 5 cycles.
  - `cpu_rdata`=0x11111111 in cycle 6; second LW 0x44 hits with stall 0 and returns 0x22222222.
- Memory word 0x80 = 0x8000_80F0 after the line is filled:
  - LB 0x80 → 0xFFFF_FFF0; LBU 0x80 → 0x0000_00F0.
  - LH 0x82 → 0xFFFF_8000; LHU 0x82 → 0x0000_8000.
- SB 0x41 data 0xAB on a cached line:
  - `mem_wstrb`=0010, `mem_wdata`=0xABABABAB, 2 stall cycles then one DONE cycle.
  - Following LW 0x40 hits and returns 0x1111AB11.
- SW to uncached 0x200 data 0xDEADBEEF:
  - a single write with `mem_wstrb`=1111.
  - LW 0x200 then misses and fills.
- Conflict and backpressure: LW 0x40, then LW 0x440 (same index, SETS=16).
  - The second load refills the line; LW 0x40 misses again.
  - With ack delayed 3 cycles per word, stall lasts 17 cycles.
- Reset after the second fill ack:
  - `mem_req`=0 immediately, state IDLE.
  - Re-issued load misses and performs a full 4-word fill.
